// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 key-scheduling block.
// Holds the controller state encoding and the hex-digit to 7-segment encoder.
package arc4_pkg;

    localparam int unsigned KEY_BYTES = 3;
    localparam int unsigned MEM_DEPTH = 256;
    localparam int unsigned ADDR_W    = $clog2(MEM_DEPTH);

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StKsaRdi,
        StKsaRdj,
        StKsaWri,
        StKsaWrj,
        StDone
    } state_e;

    // Active-low segments ordered {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] seg;
        unique case (n)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/arc4_ksa_if.sv
// Board-facing I/O bundle: pushbuttons, switches, six 7-segment displays and LEDs.
// slave is the design side, master is the board/bench side.
interface arc4_ksa_if;

    logic [3:0] key;
    logic [9:0] sw;
    logic [6:0] hex0;
    logic [6:0] hex1;
    logic [6:0] hex2;
    logic [6:0] hex3;
    logic [6:0] hex4;
    logic [6:0] hex5;
    logic [9:0] ledr;

    modport slave (
        input  key,
        input  sw,
        output hex0,
        output hex1,
        output hex2,
        output hex3,
        output hex4,
        output hex5,
        output ledr
    );

    modport master (
        output key,
        output sw,
        input  hex0,
        input  hex1,
        input  hex2,
        input  hex3,
        input  hex4,
        input  hex5,
        input  ledr
    );

endinterface

// File: rtl/s_mem.sv
// 256x8 single-port state RAM: synchronous write, registered read (1-cycle latency).
// A read of the address being written returns the old contents.
module s_mem
    import arc4_pkg::*;
(
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [7:0]        i_wdata,
    output logic [7:0]        o_rdata
);

    logic [7:0] r_mem [MEM_DEPTH];
    logic [7:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/arc4_ksa_top.sv
// ARC4 key-scheduling stage: latch key, fill S with identity, run KSA in place,
// then expose S[sw[7:0]] on the displays.
module arc4_ksa_top
    import arc4_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    arc4_ksa_if.slave   bus
);

    localparam logic [1:0] KIDX_LAST = 2'(KEY_BYTES - 1);

    state_e      r_state, w_state_nxt;
    logic [7:0]  r_i, w_i_nxt;
    logic [7:0]  r_j, w_j_nxt;
    logic [7:0]  r_si, w_si_nxt;
    logic [23:0] r_key, w_key_nxt;
    logic [1:0]  r_kidx, w_kidx_nxt;

    logic        w_we;
    logic [7:0]  w_addr;
    logic [7:0]  w_wdata;
    logic [7:0]  w_rdata;
    logic [7:0]  w_kb;
    logic [7:0]  w_j_sum;
    logic        w_unused;

    assign w_unused = ^bus.key;

    s_mem u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (w_addr),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    // r_kidx tracks i mod KEY_BYTES so no divider is needed.
    always_comb begin
        unique case (r_kidx)
            2'd0:    w_kb = r_key[23:16];
            2'd1:    w_kb = r_key[15:8];
            default: w_kb = r_key[7:0];
        endcase
    end

    assign w_j_sum = r_j + w_rdata + w_kb;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_i     <= 8'd0;
            r_j     <= 8'd0;
            r_si    <= 8'd0;
            r_key   <= 24'd0;
            r_kidx  <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_i     <= w_i_nxt;
            r_j     <= w_j_nxt;
            r_si    <= w_si_nxt;
            r_key   <= w_key_nxt;
            r_kidx  <= w_kidx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_i_nxt     = r_i;
        w_j_nxt     = r_j;
        w_si_nxt    = r_si;
        w_key_nxt   = r_key;
        w_kidx_nxt  = r_kidx;
        w_we        = 1'b0;
        w_addr      = r_i;
        w_wdata     = r_i;

        unique case (r_state)
            StIdle: begin
                w_key_nxt   = {14'b0, bus.sw};
                w_i_nxt     = 8'd0;
                w_state_nxt = StInit;
            end
            StInit: begin
                w_we = 1'b1;
                if (r_i == 8'hFF) begin
                    w_i_nxt     = 8'd0;
                    w_j_nxt     = 8'd0;
                    w_kidx_nxt  = 2'd0;
                    w_state_nxt = StKsaRdi;
                end else begin
                    w_i_nxt = r_i + 8'd1;
                end
            end
            StKsaRdi: begin
                w_state_nxt = StKsaRdj;
            end
            StKsaRdj: begin
                w_si_nxt    = w_rdata;
                w_addr      = w_j_sum;
                w_j_nxt     = w_j_sum;
                w_state_nxt = StKsaWri;
            end
            StKsaWri: begin
                // When j == i the read above saw S[i] itself, so the swap is a no-op.
                w_we        = 1'b1;
                w_wdata     = w_rdata;
                w_state_nxt = StKsaWrj;
            end
            StKsaWrj: begin
                w_we    = 1'b1;
                w_addr  = r_j;
                w_wdata = r_si;
                if (r_i == 8'hFF) begin
                    w_state_nxt = StDone;
                end else begin
                    w_i_nxt     = r_i + 8'd1;
                    w_kidx_nxt  = (r_kidx == KIDX_LAST) ? 2'd0 : r_kidx + 2'd1;
                    w_state_nxt = StKsaRdi;
                end
            end
            StDone: begin
                w_addr = bus.sw[7:0];
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_comb begin
        bus.ledr = 10'd0;
        bus.hex0 = SEG_BLANK;
        bus.hex1 = SEG_BLANK;
        bus.hex2 = SEG_BLANK;
        bus.hex3 = SEG_BLANK;
        bus.hex4 = SEG_BLANK;
        bus.hex5 = SEG_BLANK;

        bus.ledr[0] = (r_state != StIdle) && (r_state != StDone);

        if (r_state == StDone) begin
            bus.ledr[9] = 1'b1;
            bus.hex3    = hex_to_seg(bus.sw[7:4]);
            bus.hex2    = hex_to_seg(bus.sw[3:0]);
            bus.hex1    = hex_to_seg(w_rdata[7:4]);
            bus.hex0    = hex_to_seg(w_rdata[3:0]);
        end
    end

endmodule

// File: tb/tb_arc4_ksa_top.sv
// Self-checking bench for arc4_ksa_top: runs the key schedule for several keys and
// compares S (read back through the displays) against a software ARC4 KSA.
module tb_arc4_ksa_top;

    logic clk = 1'b0;
    logic rst = 1'b1;

    arc4_ksa_if bus ();

    arc4_ksa_top dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] m_s [256];

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Textbook ARC4 KSA on a 3-byte key, key byte 0 being the most significant.
    task automatic model(input logic [23:0] k);
        int j;
        logic [7:0] kb;
        logic [7:0] t;
        for (int i = 0; i < 256; i++) m_s[i] = 8'(i);
        j = 0;
        for (int i = 0; i < 256; i++) begin
            case (i % 3)
                0:       kb = k[23:16];
                1:       kb = k[15:8];
                default: kb = k[7:0];
            endcase
            j = (j + int'(m_s[i]) + int'(kb)) % 256;
            t = m_s[i];
            m_s[i] = m_s[j];
            m_s[j] = t;
        end
    endtask

    // Reset, start with key k; abort_at>0 returns early at that edge, toggle scrambles sw.
    task automatic run(input logic [9:0] k, input int abort_at, input bit toggle);
        int done_at;
        bus.sw = k;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ledr", 64'(bus.ledr), 64'd0);
        chk("reset_hex", {bus.hex5, bus.hex4, bus.hex3, bus.hex2, bus.hex1, bus.hex0},
            {6{7'h7F}});
        rst = 1'b0;
        done_at = 0;
        for (int n = 1; n <= 2000; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) chk("busy_start", {bus.ledr[9], bus.ledr[0]}, 2'b01);
            if (n == 258) chk("init_s200", 64'(dut.u_mem.r_mem[200]), 64'd200);
            if (abort_at != 0 && n == abort_at) return;
            if (toggle && (n % 50 == 0)) bus.sw = 10'($urandom);
            if (bus.ledr[9] === 1'b1) begin
                done_at = n;
                break;
            end
        end
        chk("done_edge", 64'(done_at), 64'd1281);
        chk("done_busy_low", 64'(bus.ledr[8:0]), 64'd0);
    endtask

    task automatic verify(input logic [9:0] k);
        bit   seen [256];
        int   distinct;
        int   bad;
        logic [27:0] exp;
        model({14'b0, k});
        distinct = 0;
        for (int a = 0; a < 256; a++) seen[a] = 1'b0;
        for (int a = 0; a < 256; a++) begin
            if (!seen[dut.u_mem.r_mem[a]]) distinct++;
            seen[dut.u_mem.r_mem[a]] = 1'b1;
        end
        chk("permutation", 64'(distinct), 64'd256);
        bad = 0;
        for (int a = 0; a < 256; a++) begin
            bus.sw = 10'(a);
            @(posedge clk);
            #1;
            exp = {seg7(4'(a >> 4)), seg7(4'(a)), seg7(m_s[a][7:4]), seg7(m_s[a][3:0])};
            if ({bus.hex3, bus.hex2, bus.hex1, bus.hex0} !== exp) bad++;
        end
        chk("readout_mismatches", 64'(bad), 64'd0);
        chk("done_blank45", {bus.hex5, bus.hex4}, {2{7'h7F}});
    endtask

    initial begin
        logic [9:0] k;
        bus.key = 4'd0;
        bus.sw  = 10'd0;

        run(10'h33C, 0, 1'b0);
        verify(10'h33C);
        bus.key = 4'($urandom);
        bus.sw  = 10'h005;
        @(posedge clk);
        #1;
        chk("readout_hex3", 64'(bus.hex3), 64'h40);
        chk("readout_hex2", 64'(bus.hex2), 64'h12);
        chk("readout_data", {bus.hex1, bus.hex0}, {seg7(m_s[5][7:4]), seg7(m_s[5][3:0])});

        run(10'h000, 0, 1'b0);
        verify(10'h000);

        run(10'($urandom), 700, 1'b0);
        run(10'h001, 0, 1'b0);
        verify(10'h001);

        k = 10'($urandom);
        run(k, 0, 1'b1);
        verify(k);

        for (int r = 0; r < 2; r++) begin
            k = 10'($urandom);
            run(k, 0, 1'b0);
            verify(k);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
